// File: rtl/qarma_ctr_keystream.sv
// rtl/qarma_ctr_keystream.sv - counter-mode keystream sequencer around a Qarma64 core
module qarma_ctr_keystream #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [31:0]             nonce,
  input  logic [31:0]             ctr_init,
  input  logic [15:0]             nblocks,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             ctr_cur,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    core_nrst,
  output logic [63:0]             core_in,
  input  logic [63:0]             core_out,
  input  logic                    core_rdy,
  output logic                    ks_valid,
  input  logic                    ks_ready,
  output logic [63:0]             ks_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_PUSH
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [31:0]   nonce_q;
  logic [15:0]   remaining;
  logic [63:0]   capture;
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_nxt;

  logic full;
  logic push;
  logic pop;
  logic accept;
  logic zero_start;
  logic last_push;
  logic grab;

  // Next-state and per-cycle control strobes; abort overrides everything
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    zero_start = 1'b0;
    push       = 1'b0;
    last_push  = 1'b0;
    grab       = 1'b0;
    full       = (level == FULL_LEVEL);
    pop        = ks_valid && ks_ready && !abort;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (nblocks != 16'd0) begin
              accept    = 1'b1;
              state_nxt = S_LOAD;
            end else begin
              zero_start = 1'b1;
            end
          end
        end
        S_LOAD: begin
          state_nxt = S_RUN;
        end
        S_RUN: begin
          if (core_rdy) begin
            grab      = 1'b1;
            state_nxt = S_PUSH;
          end
        end
        S_PUSH: begin
          // Push is judged against the pre-pop level, so a full FIFO stalls here
          if (!full) begin
            push = 1'b1;
            if (remaining == 16'd1) begin
              last_push = 1'b1;
              state_nxt = S_IDLE;
            end else begin
              state_nxt = S_LOAD;
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
    level_nxt = level + LW'(push) - LW'(pop);
  end

  // FSM state register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered outputs, run bookkeeping and FIFO pointers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      ctr_cur   <= 32'd0;
      core_nrst <= 1'b0;
      core_in   <= 64'd0;
      nonce_q   <= 32'd0;
      remaining <= 16'd0;
      capture   <= 64'd0;
      level     <= '0;
      ks_valid  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      done      <= last_push || zero_start;
      busy      <= (state_nxt != S_IDLE);
      // The core runs in RUN and must keep its result held through a stalled PUSH
      core_nrst <= (state_nxt == S_RUN) || (state_nxt == S_PUSH);
      if (accept) begin
        nonce_q   <= nonce;
        ctr_cur   <= ctr_init;
        remaining <= nblocks;
        core_in   <= {nonce, ctr_init};
      end
      if (grab) begin
        capture <= core_out;
      end
      if (push) begin
        ctr_cur   <= ctr_cur + 32'd1;
        remaining <= remaining - 16'd1;
        core_in   <= {nonce_q, ctr_cur + 32'd1};
        wr_ptr    <= wr_ptr + 1'b1;
      end
      if (abort) begin
        level    <= '0;
        ks_valid <= 1'b0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        level    <= level_nxt;
        ks_valid <= (level_nxt != '0);
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
    end
  end

  // FIFO storage; contents need no reset because the head is masked when empty
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= capture;
    end
  end

  assign ks_data = (level != '0) ? mem[rd_ptr] : 64'd0;

endmodule

// File: tb/tb_qarma_ctr_keystream.sv
// tb/tb_qarma_ctr_keystream.sv - self-checking bench for qarma_ctr_keystream
module tb_qarma_ctr_keystream;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        nrst;
  logic        start;
  logic        abort;
  logic [31:0] nonce;
  logic [31:0] ctr_init;
  logic [15:0] nblocks;
  logic        busy;
  logic        done;
  logic [31:0] ctr_cur;
  logic [2:0]  level;
  logic        core_nrst;
  logic [63:0] core_in;
  logic [63:0] core_out;
  logic        core_rdy;
  logic        ks_valid;
  logic        ks_ready;
  logic [63:0] ks_data;

  int errors = 0;
  int checks = 0;
  int lat = 5;
  int core_cnt = 0;
  int done_cnt = 0;
  logic [63:0] key = 64'h0;
  logic prev_cn = 1'b0;
  logic [63:0] got_words[$];
  logic [63:0] got_in[$];

  always #5 clk = ~clk;

  qarma_ctr_keystream #(.DEPTH(DEPTH)) dut (
    .clk(clk), .nrst(nrst), .start(start), .abort(abort),
    .nonce(nonce), .ctr_init(ctr_init), .nblocks(nblocks),
    .busy(busy), .done(done), .ctr_cur(ctr_cur), .level(level),
    .core_nrst(core_nrst), .core_in(core_in), .core_out(core_out),
    .core_rdy(core_rdy), .ks_valid(ks_valid), .ks_ready(ks_ready),
    .ks_data(ks_data)
  );

  function automatic logic [63:0] cipher(input logic [63:0] x);
    logic [63:0] y;
    y = x ^ key;
    y = y * 64'h9E3779B97F4A7C15;
    y = y ^ (y >> 29);
    return y ^ {y[31:0], y[63:32]};
  endfunction

  // Core model: result valid lat cycles after reset release, held while out of reset
  always @(posedge clk) begin
    if (!core_nrst) core_cnt <= 0;
    else if (core_cnt < 1000) core_cnt <= core_cnt + 1;
  end
  assign core_rdy = core_nrst && (core_cnt >= lat);
  assign core_out = core_rdy ? cipher(core_in) : 64'h0123456789ABCDEF;

  // Observation recorder: popped words, core inputs at each core start, done pulses
  always @(negedge clk) begin
    if (nrst) begin
      if (ks_valid && ks_ready) got_words.push_back(ks_data);
      if (done) done_cnt++;
      if (core_nrst && !prev_cn) got_in.push_back(core_in);
    end
    prev_cn = core_nrst;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    got_words.delete();
    got_in.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start(input logic [31:0] nn, input logic [31:0] cc, input logic [15:0] nb);
    nonce = nn;
    ctr_init = cc;
    nblocks = nb;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int cyc);
    cyc = 1;
    while (!done && cyc < 800) begin
      step();
      cyc++;
    end
    if (!done) chk({tag, "_timeout"}, 64'(done), 64'd1);
  endtask

  task automatic wait_level(input string tag, input int target);
    int n;
    n = 0;
    while (int'(level) != target && n < 800) begin
      step();
      n++;
    end
    chk(tag, 64'(level), 64'(target));
  endtask

  task automatic expect_run(input string tag, input logic [31:0] nn, input logic [31:0] c0, input int n);
    logic [63:0] e;
    logic [63:0] o;
    logic [31:0] c;
    chk({tag, "_n_core_in"}, 64'(got_in.size()), 64'(n));
    chk({tag, "_n_words"}, 64'(got_words.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      c = c0 + 32'(i);
      e = {nn, c};
      o = (i < got_in.size()) ? got_in[i] : 64'hx;
      chk($sformatf("%s_core_in%0d", tag, i), o, e);
      o = (i < got_words.size()) ? got_words[i] : 64'hx;
      chk($sformatf("%s_word%0d", tag, i), o, cipher(e));
    end
  endtask

  initial begin
    int cyc;
    int n;
    logic [31:0] rn;
    logic [31:0] rc;
    nrst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    ks_ready = 1'b0;
    nonce = '0;
    ctr_init = '0;
    nblocks = '0;
    key = {$urandom(), $urandom()};
    repeat (3) step();

    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_ks_valid", 64'(ks_valid), 64'd0);
    chk("rst_ks_data", ks_data, 64'd0);
    chk("rst_core_nrst", 64'(core_nrst), 64'd0);
    chk("rst_core_in", core_in, 64'd0);
    chk("rst_ctr_cur", 64'(ctr_cur), 64'd0);
    nrst = 1'b1;
    step();

    // Basic run with a 5-cycle core
    clear_obs();
    lat = 5;
    ks_ready = 1'b1;
    pulse_start(32'hDEADBEEF, 32'h10, 16'd3);
    chk("basic_busy_c1", 64'(busy), 64'd1);
    chk("basic_core_nrst_c1", 64'(core_nrst), 64'd0);
    chk("basic_core_in_c1", core_in, 64'hDEADBEEF00000010);
    step();
    chk("basic_core_nrst_c2", 64'(core_nrst), 64'd1);
    wait_done("basic", cyc);
    cyc = cyc + 1;
    chk("basic_done_cycle", 64'(cyc), 64'(1 + 3 * (5 + 3)));
    chk("basic_busy_at_done", 64'(busy), 64'd0);
    step();
    step();
    chk("basic_done_cnt", 64'(done_cnt), 64'd1);
    chk("basic_ctr_cur", 64'(ctr_cur), 64'h13);
    expect_run("basic", 32'hDEADBEEF, 32'h10, 3);

    // Backpressure: fill FIFO, stall in PUSH, then drain
    clear_obs();
    lat = $urandom_range(1, 6);
    rn = $urandom();
    rc = $urandom();
    ks_ready = 1'b0;
    pulse_start(rn, rc, 16'd6);
    wait_level("bp_fill", 4);
    repeat (lat + 6) step();
    chk("bp_level", 64'(level), 64'd4);
    chk("bp_core_nrst", 64'(core_nrst), 64'd1);
    chk("bp_busy", 64'(busy), 64'd1);
    chk("bp_ks_valid", 64'(ks_valid), 64'd1);
    chk("bp_head", ks_data, cipher({rn, rc}));
    chk("bp_ctr_cur", 64'(ctr_cur), 64'(rc + 32'd4));
    chk("bp_no_done", 64'(done_cnt), 64'd0);
    ks_ready = 1'b1;
    wait_done("bp", cyc);
    repeat (3) step();
    chk("bp_done_cnt", 64'(done_cnt), 64'd1);
    chk("bp_level_end", 64'(level), 64'd0);
    expect_run("bp", rn, rc, 6);

    // Counter wrap
    clear_obs();
    lat = 2;
    rn = $urandom();
    pulse_start(rn, 32'hFFFFFFFE, 16'd3);
    wait_done("wrap", cyc);
    repeat (3) step();
    chk("wrap_ctr_cur", 64'(ctr_cur), 64'd1);
    expect_run("wrap", rn, 32'hFFFFFFFE, 3);

    // Abort mid-RUN on block 2 with one word queued
    clear_obs();
    lat = 6;
    rc = $urandom();
    ks_ready = 1'b0;
    pulse_start($urandom(), rc, 16'd4);
    wait_level("abort_q1", 1);
    n = 0;
    while (!core_nrst && n < 50) begin
      step();
      n++;
    end
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_level", 64'(level), 64'd0);
    chk("abort_ks_valid", 64'(ks_valid), 64'd0);
    chk("abort_ks_data", ks_data, 64'd0);
    chk("abort_core_nrst", 64'(core_nrst), 64'd0);
    chk("abort_ctr_cur", 64'(ctr_cur), 64'(rc + 32'd1));
    repeat (10) step();
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    chk("abort_idle", 64'(busy), 64'd0);
    clear_obs();
    rn = $urandom();
    rc = $urandom();
    ks_ready = 1'b1;
    pulse_start(rn, rc, 16'd2);
    wait_done("after_abort", cyc);
    repeat (3) step();
    chk("after_abort_done_cnt", 64'(done_cnt), 64'd1);
    expect_run("after_abort", rn, rc, 2);

    // start with nblocks=0
    clear_obs();
    pulse_start($urandom(), $urandom(), 16'd0);
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_busy", 64'(busy), 64'd0);
    chk("zero_core_nrst", 64'(core_nrst), 64'd0);
    step();
    chk("zero_done_off", 64'(done), 64'd0);
    chk("zero_core_nrst2", 64'(core_nrst), 64'd0);

    // start while busy is ignored
    clear_obs();
    lat = 3;
    rn = $urandom();
    rc = $urandom();
    pulse_start(rn, rc, 16'd2);
    step();
    step();
    pulse_start(~rn, rc + 32'h100, 16'd7);
    wait_done("busy_start", cyc);
    repeat (10) step();
    chk("busy_start_idle", 64'(busy), 64'd0);
    chk("busy_start_done_cnt", 64'(done_cnt), 64'd1);
    chk("busy_start_ctr_cur", 64'(ctr_cur), 64'(rc + 32'd2));
    expect_run("busy_start", rn, rc, 2);

    // start and abort together
    clear_obs();
    abort = 1'b1;
    pulse_start($urandom(), $urandom(), 16'd3);
    abort = 1'b0;
    chk("sa_busy", 64'(busy), 64'd0);
    chk("sa_core_nrst", 64'(core_nrst), 64'd0);
    repeat (4) step();
    chk("sa_busy_later", 64'(busy), 64'd0);
    chk("sa_no_done", 64'(done_cnt), 64'd0);

    // Asynchronous reset during PUSH with two words queued
    clear_obs();
    lat = 4;
    ks_ready = 1'b0;
    pulse_start($urandom(), $urandom(), 16'd4);
    wait_level("rst_mid_q2", 2);
    n = 0;
    while (!core_rdy && n < 50) begin
      step();
      n++;
    end
    step();
    chk("rst_mid_pre_level", 64'(level), 64'd2);
    #2;
    nrst = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    chk("rst_mid_level", 64'(level), 64'd0);
    chk("rst_mid_ks_valid", 64'(ks_valid), 64'd0);
    chk("rst_mid_ks_data", ks_data, 64'd0);
    chk("rst_mid_core_nrst", 64'(core_nrst), 64'd0);
    chk("rst_mid_core_in", core_in, 64'd0);
    chk("rst_mid_ctr_cur", 64'(ctr_cur), 64'd0);
    step();
    nrst = 1'b1;
    step();
    step();
    chk("rst_mid_after_busy", 64'(busy), 64'd0);
    chk("rst_mid_after_level", 64'(level), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
